// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like bus between the instruction-fetch and
// data sides. One transaction in flight at a time (IDLE -> ADDR -> DATA).
// Optional build macro ARB_ROUND_ROBIN_EN: ties go to the side not served
// last instead of the fixed DATA_FIRST priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // shared bus
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_e              state_q, state_d;
  logic                own_q,   own_d;     // 0 = instruction side, 1 = data side
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                wr_q,    wr_d;
  logic [1:0]          size_q,  size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                tie_data_c;
  logic                grant_inst_c;
  logic                grant_data_c;
  logic                complete_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q, last_d;     // side served last: 0 = inst, 1 = data

  // Tie goes to whichever side was not served last
  always_comb begin
    tie_data_c = ~last_q;
  end

  // Track the side of each grant
  always_comb begin
    last_d = last_q;
    if (grant_data_c) begin
      last_d = 1'b1;
    end else if (grant_inst_c) begin
      last_d = 1'b0;
    end
  end

  // Last-served register; resets to "data served last" so inst wins first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed tie-break
  always_comb begin
    tie_data_c = DATA_FIRST;
  end
`endif

  // Winner selection: only from IDLE and never while reset is asserted
  always_comb begin
    grant_inst_c = 1'b0;
    grant_data_c = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (inst_req && data_req) begin
        grant_data_c = tie_data_c;
        grant_inst_c = ~tie_data_c;
      end else begin
        grant_data_c = data_req;
        grant_inst_c = inst_req;
      end
    end
  end

  // Next-state and captured-request logic
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data_c) begin
          own_d   = 1'b1;
          addr_d  = data_addr;
          wr_d    = data_wr;
          size_d  = data_size;
          wdata_d = data_wdata;
          state_d = ADDR;
        end else if (grant_inst_c) begin
          own_d   = 1'b0;
          addr_d  = inst_addr;
          wr_d    = 1'b0;
          size_d  = SIZE_WORD;
          wdata_d = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured fields; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Completion is only honoured in DATA and suppressed during reset
  always_comb begin
    complete_c = !rst && (state_q == DATA) && bus_data_ok;
  end

  // Handshake and bus outputs
  always_comb begin
    inst_addr_ok = grant_inst_c;
    data_addr_ok = grant_data_c;
    inst_data_ok = complete_c && !own_q;
    data_data_ok = complete_c && own_q;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
    bus_req      = (state_q == ADDR);
    bus_wr       = wr_q;
    bus_size     = size_q;
    bus_addr     = addr_q;
    bus_wdata    = wdata_q;
    busy         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed stimulus with scoreboard queues for
// grants (addr_ok) and completions (data_ok), checked by a forked monitor.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          busy;

  mem_bus_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DATA_FIRST(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic          exp_grant_q[$];   // expected grant side: 0 = inst, 1 = data
  logic [DW:0]   exp_resp_q[$];    // {side, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the scoreboards whenever the DUT pulses a handshake
  task automatic monitor();
    logic        s;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        if (exp_grant_q.size() == 0) begin
          check("unexpected_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
        end else begin
          s = exp_grant_q.pop_front();
          check("grant_side", 32'({data_addr_ok, inst_addr_ok}), s ? 32'd2 : 32'd1);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_data_ok", 32'({data_data_ok, inst_data_ok}), 32'd0);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_side", 32'({data_data_ok, inst_data_ok}), e[DW] ? 32'd2 : 32'd1);
          check("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e[DW-1:0]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus responder for one granted transaction, entered in the first ADDR cycle
  task automatic serve(input int stall, input bit spur, input logic [31:0] addr,
                       input bit wr, input logic [1:0] size, input logic [31:0] wdata,
                       input logic [31:0] rdata);
    for (int i = 0; i <= stall; i++) begin
      bus_addr_ok = (i == stall);
      bus_data_ok = spur && (i != stall);
      bus_rdata   = 32'hBAD0BAD0;
      #2;
      check("bus_req_addr", 32'(bus_req), 32'd1);
      check("bus_addr", bus_addr, addr);
      check("bus_wr", 32'(bus_wr), 32'(wr));
      check("bus_size", 32'(bus_size), 32'(size));
      if (wr) check("bus_wdata", bus_wdata, wdata);
      check("no_addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      check("no_data_ok_addr", 32'({inst_data_ok, data_data_ok}), 32'd0);
      tick();
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    #2;
    check("bus_req_data", 32'(bus_req), 32'd0);
    check("busy_data", 32'(busy), 32'd1);
    tick();
    bus_data_ok = 1'b0;
  endtask

  initial begin
    logic        w;
    logic [31:0] rd;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    fork
      monitor();
    join_none

    // Reset state, requests present during reset must not be granted
    tick();
    inst_req = 1'b1;
    data_req = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wr", 32'(bus_wr), 32'd0);
    check("rst_bus_size", 32'(bus_size), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    tick();
    rst      = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;

    // Single fetch
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00000;
    exp_grant_q.push_back(1'b0);
    exp_resp_q.push_back({1'b0, 32'h24080001});
    #2;
    check("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_req = 1'b0;
    serve(0, 1'b0, 32'hBFC00000, 1'b0, 2'd2, 32'd0, 32'h24080001);
    #2;
    check("fetch_busy_low", 32'(busy), 32'd0);
    check("fetch_drained", 32'(exp_resp_q.size()), 32'd0);

    // Tie: data store wins, fetch granted on first IDLE after completion
    tick();
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC00004;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h80000010;
    data_wdata = 32'hDEADBEEF;
    exp_grant_q.push_back(1'b1);
    exp_resp_q.push_back({1'b1, 32'h00000000});
    #2;
    check("tie_data_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd1);
    tick();
    data_req = 1'b0;
    data_wr  = 1'b0;
    serve(0, 1'b0, 32'h80000010, 1'b1, 2'd2, 32'hDEADBEEF, 32'h00000000);
    exp_grant_q.push_back(1'b0);
    exp_resp_q.push_back({1'b0, 32'h8C080000});
    #2;
    check("tie_inst_after", 32'({inst_addr_ok, data_addr_ok}), 32'd2);
    tick();
    inst_req = 1'b0;
    serve(0, 1'b0, 32'hBFC00004, 1'b0, 2'd2, 32'd0, 32'h8C080000);

    // Bus stall: addr_ok held low 4 cycles on a half-word load
    tick();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd1;
    data_addr = 32'h80000020;
    exp_grant_q.push_back(1'b1);
    exp_resp_q.push_back({1'b1, 32'h0000BEEF});
    #2;
    tick();
    data_req = 1'b0;
    serve(4, 1'b0, 32'h80000020, 1'b0, 2'd1, 32'd0, 32'h0000BEEF);

    // Spurious bus_data_ok during ADDR
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00008;
    exp_grant_q.push_back(1'b0);
    exp_resp_q.push_back({1'b0, 32'h3C1DA000});
    #2;
    tick();
    inst_req = 1'b0;
    serve(2, 1'b1, 32'hBFC00008, 1'b0, 2'd2, 32'd0, 32'h3C1DA000);
    #2;
    check("spur_drained", 32'(exp_resp_q.size()), 32'd0);

    // Reset in DATA abandons the load
    tick();
    data_req  = 1'b1;
    data_size = 2'd2;
    data_addr = 32'h80000030;
    exp_grant_q.push_back(1'b1);
    #2;
    tick();
    data_req    = 1'b0;
    bus_addr_ok = 1'b1;
    #2;
    check("abandon_bus_req", 32'(bus_req), 32'd1);
    tick();
    bus_addr_ok = 1'b0;
    rst         = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h11111111;
    #2;
    check("abandon_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    tick();
    rst         = 1'b0;
    bus_data_ok = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'hBFC0000C;
    exp_grant_q.push_back(1'b0);
    exp_resp_q.push_back({1'b0, 32'h27BDFFE8});
    #2;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_bus_req", 32'(bus_req), 32'd0);
    check("post_rst_accept", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_req = 1'b0;
    serve(0, 1'b0, 32'hBFC0000C, 1'b0, 2'd2, 32'd0, 32'h27BDFFE8);

    // Both sides requesting continuously for 4 transactions, from fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst_req  = 1'b1;
      data_req  = 1'b1;
      data_wr   = 1'b0;
      data_size = 2'd2;
      inst_addr = 32'hBFC00100 + 32'(k * 4);
      data_addr = 32'h80000100 + 32'(k * 4);
`ifdef ARB_ROUND_ROBIN_EN
      w = ((k % 2) == 1);
`else
      w = 1'b1;
`endif
      rd = 32'hA5000000 + 32'(k);
      exp_grant_q.push_back(w);
      exp_resp_q.push_back({w, rd});
      #2;
      check("cont_grant", 32'({inst_addr_ok, data_addr_ok}), w ? 32'd1 : 32'd2);
      tick();
      serve(0, 1'b0, w ? data_addr : inst_addr, 1'b0, 2'd2, 32'd0, rd);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
    tick();

    check("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
    check("resp_q_empty", 32'(exp_resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
